// File: rtl/zx_pkg.sv
// Shared definitions for the ULA output-port slice: the port number,
// the write-capture state encoding, border FIFO depth and the DAC level helper.
package zx_pkg;

  localparam logic [7:0] ZX_PORT_FE      = 8'hFE;
  localparam int         BCHG_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE         = 1'b0,
    ST_WAIT_RELEASE = 1'b1
  } zx_wr_state_t;

  // EAR dominates the speaker mix; MIC leaks through at a quarter of that level.
  function automatic logic [7:0] zx_dac_level(input logic ear, input logic mic);
    return (ear ? 8'hC0 : 8'h00) + (mic ? 8'h30 : 8'h00);
  endfunction

endpackage

// File: rtl/zx_bchg_fifo.sv
// Four-entry FIFO of border colour changes. A pop and a push in the same
// edge are allowed even when full; an unaccepted push into a full FIFO is
// dropped and latches a sticky overflow flag. When empty, the data output
// keeps showing the most recently popped colour.
module zx_bchg_fifo
  import zx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [2:0] i_push_data,
  input  logic       i_pop,
  output logic [2:0] o_data,
  output logic       o_valid,
  output logic       o_full,
  output logic       o_ovf
);

  logic [2:0] r_mem [0:BCHG_FIFO_DEPTH-1];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic [2:0] r_last;
  logic       r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  assign w_empty   = (r_count == 3'd0);
  assign w_full    = (r_count == 3'(BCHG_FIFO_DEPTH));
  assign w_pop     = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop);
  assign w_drop    = i_push && w_full && !w_pop;

  assign o_valid = !w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;
  assign o_data  = w_empty ? r_last : r_mem[r_rd_ptr];

  // Storage array: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers, occupancy, held head value and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      r_last   <= 3'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/zx_ula_out.sv
// ZX Spectrum ULA output side: captures CPU writes to port FE into the
// border/MIC/EAR latches once per bus cycle, queues border colour changes
// for a consumer, and drives the speaker.
// Build option: define ZX_ULA_OUT_AUDIO_DAC_EN to drive the speaker from a
// first-order delta-sigma mix of EAR and MIC instead of EAR directly.
module zx_ula_out
  import zx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        wr_n,
  input  logic [15:0] ad,
  input  logic [7:0]  data_bus,
  output logic [2:0]  border,
  output logic        mic,
  output logic        ear,
  output logic        audio_out,
  output logic        bchg_valid,
  output logic [2:0]  bchg_data,
  input  logic        bchg_ready,
  output logic        bchg_ovf
);

  zx_wr_state_t r_state;
  logic [2:0]   r_border;
  logic         r_mic;
  logic         r_ear;

  logic w_hit;
  logic w_capture;
  logic w_push;
  logic w_fifo_full_unused;
  logic w_unused_bits;

  // The ULA decodes only the low address byte; the upper data bits have no function.
  assign w_unused_bits = ^{ad[15:8], data_bus[7:5]};

  assign w_hit     = !ce && !wr_n && (ad[7:0] == ZX_PORT_FE);
  assign w_capture = (r_state == ST_IDLE) && w_hit;
  assign w_push    = w_capture && (data_bus[2:0] != r_border);

  assign border = r_border;
  assign mic    = r_mic;
  assign ear    = r_ear;

  // Write-capture FSM: latch once, then wait for the bus cycle to end.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_border <= 3'b000;
      r_mic    <= 1'b0;
      r_ear    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_border <= data_bus[2:0];
            r_mic    <= data_bus[3];
            r_ear    <= data_bus[4];
            r_state  <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (wr_n || ce) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  zx_bchg_fifo u_bchg_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (data_bus[2:0]),
    .i_pop       (bchg_ready),
    .o_data      (bchg_data),
    .o_valid     (bchg_valid),
    .o_full      (w_fifo_full_unused),
    .o_ovf       (bchg_ovf)
  );

`ifdef ZX_ULA_OUT_AUDIO_DAC_EN
  logic [8:0] r_acc;

  assign audio_out = r_acc[8];

  // Delta-sigma accumulator: the carry out density equals level/256.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= 9'd0;
    end else begin
      r_acc <= {1'b0, r_acc[7:0]} + {1'b0, zx_dac_level(r_ear, r_mic)};
    end
  end
`else
  logic r_audio;

  assign audio_out = r_audio;

  // Speaker mirrors EAR, updated on the same capture edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_audio <= 1'b0;
    end else if (w_capture) begin
      r_audio <= data_bus[4];
    end
  end
`endif

endmodule
